// File: rtl/gsu_pkg.sv
// GSU shared definitions: default geometry, special register indices, lane enables.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gsu_pkg;

  localparam int GSU_DATA_WIDTH = 16;
  localparam int GSU_NUM_REGS   = 16;

  // Architectural register indices with side effects.
  localparam int R_PC      = 15;
  localparam int R_ROMADDR = 14;

  // Per-register lane write enables.
  typedef struct packed {
    logic high;
    logic low;
  } lane_en_t;

endpackage : gsu_pkg

// File: rtl/gsu_byte_lane_reg.sv
// One GSU register with independent low/high lane writes and an optional +1 step.
// Latency: state updates on the rising edge; o_next is the combinational post-edge value.
// Backpressure: none; every enabled lane is written on every edge.
//
// Ports:
//   clk, reset_n : clock, async active-low reset (loads RESET_VAL)
//   i_lane_en    : {high, low} lane write enables
//   i_inc        : add 1 to the full word; written lanes override the sum
//   i_wr_data    : write data
//   o_q          : current register contents
//   o_next       : value the register takes on the next edge
module gsu_byte_lane_reg
  import gsu_pkg::*;
#(
  parameter int                    DATA_WIDTH = GSU_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  lane_en_t              i_lane_en,
  input  logic                  i_inc,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic [DATA_WIDTH-1:0] o_q,
  output logic [DATA_WIDTH-1:0] o_next
);

  localparam int LW = DATA_WIDTH / 2;

  logic [DATA_WIDTH-1:0] r_q;
  logic [DATA_WIDTH-1:0] w_base;

  // Unwritten lanes come from the (possibly incremented) current value, so the
  // carry out of the low lane reaches the high lane only when it is not written.
  assign w_base = i_inc ? (r_q + DATA_WIDTH'(1)) : r_q;

  assign o_next[LW-1:0]          = i_lane_en.low  ? i_wr_data[LW-1:0]          : w_base[LW-1:0];
  assign o_next[DATA_WIDTH-1:LW] = i_lane_en.high ? i_wr_data[DATA_WIDTH-1:LW] : w_base[DATA_WIDTH-1:LW];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q <= RESET_VAL;
    end else begin
      r_q <= o_next;
    end
  end

  assign o_q = r_q;

endmodule : gsu_byte_lane_reg

// File: rtl/gsu_register_bank.sv
// GSU general-register bank: addressed lane writes, PC auto-increment, ROM reload strobe.
// Latency: writes on the edge; read ports registered, 1 cycle, with write/increment bypass.
// Backpressure: none; a write or read is accepted on every cycle.
//
// Ports:
//   clk, reset_n              : clock, async active-low reset
//   wr_en                     : full-word write (overrides lane vetoes)
//   wr_low_en / wr_high_en    : lane write requests
//   wr_low_dis / wr_high_dis  : lane vetoes for the lane requests
//   wr_addr, wr_data          : write target and data (out-of-range targets ignored)
//   rd_a_addr / rd_b_addr     : read addresses (out-of-range reads return 0)
//   rd_a_data / rd_b_data     : registered read data
//   pc_inc, pc_out            : PC increment request and live PC register value
//   rom_reload                : one-cycle strobe after any write to ROMADDR_REG
module gsu_register_bank
  import gsu_pkg::*;
#(
  parameter int                    DATA_WIDTH  = GSU_DATA_WIDTH,
  parameter int                    NUM_REGS    = GSU_NUM_REGS,
  parameter int                    ADDR_WIDTH  = 4,
  parameter int                    PC_REG      = R_PC,
  parameter int                    ROMADDR_REG = R_ROMADDR,
  parameter logic [DATA_WIDTH-1:0] PC_RESET    = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic                  wr_low_en,
  input  logic                  wr_high_en,
  input  logic                  wr_low_dis,
  input  logic                  wr_high_dis,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_a_addr,
  input  logic [ADDR_WIDTH-1:0] rd_b_addr,
  output logic [DATA_WIDTH-1:0] rd_a_data,
  output logic [DATA_WIDTH-1:0] rd_b_data,
  input  logic                  pc_inc,
  output logic [DATA_WIDTH-1:0] pc_out,
  output logic                  rom_reload
);

  logic w_low_we;
  logic w_high_we;
  logic w_rom_hit;

  logic [DATA_WIDTH-1:0] w_q    [NUM_REGS];
  logic [DATA_WIDTH-1:0] w_next [NUM_REGS];
  logic [DATA_WIDTH-1:0] w_rd_a;
  logic [DATA_WIDTH-1:0] w_rd_b;

  logic [DATA_WIDTH-1:0] r_rd_a;
  logic [DATA_WIDTH-1:0] r_rd_b;
  logic                  r_rom_reload;

  // A full-word write wins over both lane vetoes.
  assign w_low_we  = wr_en | (wr_low_en  & ~wr_low_dis);
  assign w_high_we = wr_en | (wr_high_en & ~wr_high_dis);

  // Address decode compares against every in-range index, so an out-of-range
  // wr_addr selects nothing and has no side effects.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    lane_en_t w_en;
    assign w_en.low  = w_low_we  & (wr_addr == ADDR_WIDTH'(gi));
    assign w_en.high = w_high_we & (wr_addr == ADDR_WIDTH'(gi));

    gsu_byte_lane_reg #(
      .DATA_WIDTH (DATA_WIDTH),
      .RESET_VAL  ((gi == PC_REG) ? PC_RESET : {DATA_WIDTH{1'b0}})
    ) u_reg (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_lane_en (w_en),
      .i_inc     ((gi == PC_REG) ? pc_inc : 1'b0),
      .i_wr_data (wr_data),
      .o_q       (w_q[gi]),
      .o_next    (w_next[gi])
    );
  end

  // Read muxes select the post-edge value so a same-cycle write or PC step is
  // visible; unmatched (out-of-range) addresses fall through to 0.
  always_comb begin
    w_rd_a = '0;
    w_rd_b = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_a_addr == ADDR_WIDTH'(i)) w_rd_a = w_next[i];
      if (rd_b_addr == ADDR_WIDTH'(i)) w_rd_b = w_next[i];
    end
  end

  assign w_rom_hit = (ROMADDR_REG < NUM_REGS) &&
                     (wr_addr == ADDR_WIDTH'(ROMADDR_REG)) &&
                     (w_low_we || w_high_we);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_a       <= '0;
      r_rd_b       <= '0;
      r_rom_reload <= 1'b0;
    end else begin
      r_rd_a       <= w_rd_a;
      r_rd_b       <= w_rd_b;
      r_rom_reload <= w_rom_hit;
    end
  end

  assign rd_a_data  = r_rd_a;
  assign rd_b_data  = r_rd_b;
  assign rom_reload = r_rom_reload;
  assign pc_out     = w_q[PC_REG];

endmodule : gsu_register_bank

// File: tb/tb_gsu_register_bank.sv
module tb_gsu_register_bank;

  localparam int          DW   = 16;
  localparam int          AW   = 4;
  localparam int          NREG = 12;
  localparam int          PCI  = 11;
  localparam int          ROMI = 10;
  localparam logic [15:0] PCR  = 16'h0100;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          wr_en, wr_low_en, wr_high_en, wr_low_dis, wr_high_dis;
  logic [AW-1:0] wr_addr, rd_a_addr, rd_b_addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_a_data, rd_b_data, pc_out;
  logic          pc_inc;
  logic          rom_reload;

  always #5 clk = ~clk;

  gsu_register_bank #(
    .DATA_WIDTH  (DW),
    .NUM_REGS    (NREG),
    .ADDR_WIDTH  (AW),
    .PC_REG      (PCI),
    .ROMADDR_REG (ROMI),
    .PC_RESET    (PCR)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .wr_en       (wr_en),
    .wr_low_en   (wr_low_en),
    .wr_high_en  (wr_high_en),
    .wr_low_dis  (wr_low_dis),
    .wr_high_dis (wr_high_dis),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_a_addr   (rd_a_addr),
    .rd_b_addr   (rd_b_addr),
    .rd_a_data   (rd_a_data),
    .rd_b_data   (rd_b_data),
    .pc_inc      (pc_inc),
    .pc_out      (pc_out),
    .rom_reload  (rom_reload)
  );

  int checks   = 0;
  int failures = 0;
  int step_no  = 0;

  // Reference model: architectural register contents.
  logic [15:0] m_regs [NREG];

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s step=%0d got=%h exp=%h", tag, step_no, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m_regs[i] = 16'h0000;
    m_regs[PCI] = PCR;
  endtask

  task automatic idle_inputs();
    wr_en = 0; wr_low_en = 0; wr_high_en = 0; wr_low_dis = 0; wr_high_dis = 0;
    wr_addr = '0; wr_data = '0; rd_a_addr = '0; rd_b_addr = '0; pc_inc = 0;
  endtask

  // One clock of stimulus; model computes the post-edge state and the
  // expected registered outputs, then all four outputs are compared.
  task automatic step(input logic we, input logic le, input logic he,
                      input logic ld, input logic hd,
                      input logic [3:0] wa, input logic [15:0] wd,
                      input logic [3:0] ra, input logic [3:0] rb, input logic inc);
    logic [15:0] nxt [NREG];
    logic [15:0] mask, exp_a, exp_b;
    logic        lw, hw, exp_rom;
    @(negedge clk);
    wr_en = we; wr_low_en = le; wr_high_en = he; wr_low_dis = ld; wr_high_dis = hd;
    wr_addr = wa; wr_data = wd; rd_a_addr = ra; rd_b_addr = rb; pc_inc = inc;
    step_no++;
    lw   = we | (le & ~ld);
    hw   = we | (he & ~hd);
    mask = {(hw ? 8'hFF : 8'h00), (lw ? 8'hFF : 8'h00)};
    for (int i = 0; i < NREG; i++) nxt[i] = m_regs[i];
    if (inc) nxt[PCI] = m_regs[PCI] + 16'd1;
    if (int'(wa) < NREG) nxt[wa] = (wd & mask) | (nxt[wa] & ~mask);
    exp_rom = (int'(wa) == ROMI) && (lw || hw);
    exp_a   = (int'(ra) < NREG) ? nxt[ra] : 16'h0000;
    exp_b   = (int'(rb) < NREG) ? nxt[rb] : 16'h0000;
    for (int i = 0; i < NREG; i++) m_regs[i] = nxt[i];
    @(posedge clk);
    #1;
    chk("rd_a", rd_a_data, exp_a);
    chk("rd_b", rd_b_data, exp_b);
    chk("pc_out", pc_out, m_regs[PCI]);
    chk("rom_reload", {15'd0, rom_reload}, {15'd0, exp_rom});
  endtask

  task automatic check_reset_outputs();
    chk("rst_rd_a", rd_a_data, 16'h0000);
    chk("rst_rd_b", rd_b_data, 16'h0000);
    chk("rst_pc", pc_out, PCR);
    chk("rst_rom", {15'd0, rom_reload}, 16'h0000);
  endtask

  initial begin
    idle_inputs();
    reset_n = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    reset_n = 1;

    // Read every register after reset.
    for (int i = 0; i < NREG; i += 2)
      step(0, 0, 0, 0, 0, 4'd0, 16'h0, 4'(i), 4'(i + 1), 0);

    // Full write, vetoed low write, then high-lane write.
    step(1, 0, 0, 0, 0, 4'd3, 16'hA55A, 4'd3, 4'd0, 0);
    step(0, 1, 0, 1, 0, 4'd3, 16'h1234, 4'd3, 4'd3, 0);
    step(0, 0, 1, 0, 0, 4'd3, 16'h1234, 4'd3, 4'd3, 0);
    chk("r3_lane_merge", rd_a_data, 16'h125A);

    // Same-cycle write visible on both ports.
    step(1, 0, 0, 0, 0, 4'd5, 16'hBEEF, 4'd5, 4'd5, 0);
    chk("bypass_a", rd_a_data, 16'hBEEF);

    // PC wrap and increment merged with a high-lane write.
    step(1, 0, 0, 0, 0, 4'(PCI), 16'hFFFF, 4'(PCI), 4'd0, 0);
    step(0, 0, 0, 0, 0, 4'd0, 16'h0, 4'(PCI), 4'd0, 1);
    chk("pc_wrap", pc_out, 16'h0000);
    step(1, 0, 0, 0, 0, 4'(PCI), 16'h00FF, 4'd0, 4'd0, 0);
    step(0, 0, 1, 0, 0, 4'(PCI), 16'h12AB, 4'(PCI), 4'd0, 1);
    chk("pc_merge", pc_out, 16'h1200);

    // ROM reload strobe: single, back-to-back, fully vetoed.
    step(0, 1, 0, 0, 0, 4'(ROMI), 16'h0042, 4'(ROMI), 4'd0, 0);
    step(0, 0, 0, 0, 0, 4'd0, 16'h0, 4'd0, 4'd0, 0);
    for (int i = 0; i < 3; i++)
      step(1, 0, 0, 0, 0, 4'(ROMI), 16'(16'h7000 + i), 4'(ROMI), 4'd0, 0);
    step(0, 0, 0, 0, 0, 4'd0, 16'h0, 4'd0, 4'd0, 0);
    step(0, 1, 1, 1, 1, 4'(ROMI), 16'hFFFF, 4'(ROMI), 4'd0, 0);

    // Out-of-range writes and reads.
    step(1, 0, 0, 0, 0, 4'd15, 16'hDEAD, 4'd15, 4'd12, 0);
    step(1, 0, 0, 0, 0, 4'd12, 16'hCAFE, 4'd12, 4'(PCI), 1);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 3) == 0, 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom),
           4'($urandom_range(0, 15)), 16'($urandom),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           1'($urandom));
    end

    // Reset asserted while a write and an increment are pending.
    @(negedge clk);
    wr_en = 1; wr_addr = 4'd3; wr_data = 16'hDEAD; pc_inc = 1;
    rd_a_addr = 4'd3; rd_b_addr = 4'(PCI);
    #2 reset_n = 0;
    model_reset();
    @(posedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    idle_inputs();
    reset_n = 1;
    step(0, 0, 0, 0, 0, 4'd0, 16'h0, 4'd3, 4'(PCI), 0);
    step(0, 0, 0, 0, 0, 4'd0, 16'h0, 4'd5, 4'(ROMI), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_gsu_register_bank
